// File: rtl/stream_router_if.sv
// Byte-push side and per-channel AXI-Stream outputs of stream_router.
// master: the producer/sink side (bench); slave: the router itself.
// No storage; pure signal bundle.
interface stream_router_if #(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 5
);
  logic [DATA_W-1:0]        din;
  logic                     din_last;
  logic                     push;
  logic [NUM_CH*DATA_W-1:0] m_tdata;
  logic [NUM_CH-1:0]        m_tvalid;
  logic [NUM_CH-1:0]        m_tlast;
  logic [NUM_CH-1:0]        m_tready;

  modport master (
    output din, din_last, push, m_tready,
    input  m_tdata, m_tvalid, m_tlast
  );

  modport slave (
    input  din, din_last, push, m_tready,
    output m_tdata, m_tvalid, m_tlast
  );
endinterface

// File: rtl/stream_router.sv
// Buffers pushed words in a FIFO and routes whole packets to one of NUM_CH AXI-Stream sinks.
// Latency: push at edge N -> count=1 after N; pop at N+1 -> m_tvalid after N+1; 1 word/cycle.
// Backpressure: m_tready low holds the output register; FIFO fills, then pushes drop and set overflow.
module stream_router #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int NUM_CH = 5,
  parameter int CH_W   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  stream_router_if.slave        bus,
  input  logic [CH_W-1:0]       ch_sel,
  input  logic                  op_en,
  input  logic                  ovf_clr,
  output logic [$clog2(DEPTH):0] count,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow,
  output logic                  bad_ch
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, SEND, DROP} state_t;

  state_t              state_q, state_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic                ov_q, ov_d;
  logic                olast_q, olast_d;
  logic [DATA_W-1:0]   odata_q, odata_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                full_q, full_d, empty_q, empty_d;
  logic                overflow_q, overflow_d, bad_ch_q, bad_ch_d;

  logic [DATA_W:0]     mem [DEPTH];
  logic [DATA_W-1:0]   rd_data;
  logic                rd_last;
  logic                hs, pop, start, push_ok, ch_ok, bad_set, ovf_set;
  logic [NUM_CH-1:0]        tvalid, tlast;
  logic [NUM_CH*DATA_W-1:0] tdata;

  assign rd_data = mem[rd_ptr_q][DATA_W-1:0];
  assign rd_last = mem[rd_ptr_q][DATA_W];
  assign ch_ok   = ({1'b0, ch_sel} < (CH_W+1)'(NUM_CH));

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state: pop decision, packet start/channel lock, output register load
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    ov_d    = ov_q;
    olast_d = olast_q;
    odata_d = odata_q;
    bad_set = 1'b0;
    pop     = op_en && (count_q != '0) && (state_q == DROP || !ov_q || hs);
    // A new packet begins on any pop from IDLE, or when the last word leaves as the next is popped.
    start   = pop && (state_q == IDLE || (state_q == SEND && hs && olast_q));
    if (hs) begin
      ov_d = 1'b0;
      if (olast_q) state_d = IDLE;
    end
    if (start) begin
      if (ch_ok) begin
        ch_d    = ch_sel;
        ov_d    = 1'b1;
        olast_d = rd_last;
        odata_d = rd_data;
        state_d = SEND;
      end else begin
        bad_set = 1'b1;
        state_d = rd_last ? IDLE : DROP;
      end
    end else if (pop) begin
      if (state_q == DROP) begin
        if (rd_last) state_d = IDLE;
      end else begin
        ov_d    = 1'b1;
        olast_d = rd_last;
        odata_d = rd_data;
      end
    end
  end

  // Outputs: only the locked channel carries data; handshake is that channel's ready
  always_comb begin
    tvalid = '0;
    tlast  = '0;
    tdata  = '0;
    hs     = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ch_q == CH_W'(k)) begin
        tvalid[k]                  = ov_q;
        tlast[k]                   = olast_q;
        tdata[k*DATA_W +: DATA_W]  = odata_q;
        hs                         = ov_q && bus.m_tready[k];
      end
    end
  end

  assign bus.m_tvalid = tvalid;
  assign bus.m_tlast  = tlast;
  assign bus.m_tdata  = tdata;

  // FIFO bookkeeping and sticky flags; a set event beats a same-cycle clear
  always_comb begin
    push_ok  = bus.push && (!full_q || pop);
    ovf_set  = bus.push && full_q && !pop;
    wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop     ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push_ok && !pop)      count_d = count_q + CNT_W'(1);
    else if (!push_ok && pop) count_d = count_q - CNT_W'(1);
    full_d     = (count_d == CNT_W'(DEPTH));
    empty_d    = (count_d == '0);
    overflow_d = (overflow_q && !ovf_clr) || ovf_set;
    bad_ch_d   = (bad_ch_q && !ovf_clr) || bad_set;
  end

  // Datapath and flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_q       <= '0;
      ov_q       <= 1'b0;
      olast_q    <= 1'b0;
      odata_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
      bad_ch_q   <= 1'b0;
    end else begin
      ch_q       <= ch_d;
      ov_q       <= ov_d;
      olast_q    <= olast_d;
      odata_q    <= odata_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
      bad_ch_q   <= bad_ch_d;
    end
  end

  // Storage array; contents are only meaningful between the pointers, so no reset
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= {bus.din_last, bus.din};
  end

  assign count    = count_q;
  assign full     = full_q;
  assign empty    = empty_q;
  assign overflow = overflow_q;
  assign bad_ch   = bad_ch_q;
endmodule
